// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: round-robin block-transfer controller between cache clients
// and a single-port synchronous RAM. A granted block moves as BLOCK_WORDS
// back-to-back word accesses, and the requester gets one ack per block.
module mem_burst_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int NUM_PORTS   = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_PORTS-1:0]                      req_valid_i,
  input  logic [NUM_PORTS-1:0]                      req_rw_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [NUM_PORTS*BLOCK_WORDS*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]                      resp_ack_o,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0]         resp_rdata_o,
  output logic                                      busy_o,
  output logic [ADDR_WIDTH-1:0]                     mem_addr_o,
  output logic [DATA_WIDTH-1:0]                     mem_wdata_o,
  output logic                                      mem_we_o,
  input  logic [DATA_WIDTH-1:0]                     mem_rdata_i
);

  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = OW + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BLOCK_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [PW-1:0]                    grant_q, rr_ptr_q;
  logic                             rw_q;
  logic [ADDR_WIDTH-1:0]            base_q;
  logic [OW-1:0]                    beat_q;
  logic [RD_LATENCY-1:0]            pipe_vld_q;
  logic [OW-1:0]                    pipe_idx_q [RD_LATENCY];
  logic [CW-1:0]                    outstanding_q, outstanding_d;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] rdata_q;

  logic [PW-1:0]                    arb_idx, arb_cand;
  logic                             arb_found;
  logic                             last_beat, rd_push, rd_capture;
  logic [OW-1:0]                    cap_idx;

  // Flattened buses reshaped into word/address arrays so they can be indexed
  // directly by {grant, beat} and by the arbiter's pick.
  logic [DATA_WIDTH-1:0] wr_word   [NUM_PORTS*BLOCK_WORDS];
  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS*BLOCK_WORDS; g++) begin : g_wr_word
    assign wr_word[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_addr
    assign port_addr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign last_beat  = (beat_q == OW'(BLOCK_WORDS - 1));
  assign rd_push    = (state_q == S_ISSUE) && !rw_q;
  assign rd_capture = pipe_vld_q[RD_LATENCY-1];
  assign cap_idx    = pipe_idx_q[RD_LATENCY-1];
  assign busy_o     = (state_q != S_IDLE);
  assign resp_rdata_o = rdata_q;
  assign outstanding_d = outstanding_q + CW'(rd_push) - CW'(rd_capture);

  // Round-robin pick: first requesting port after the last one served.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      arb_cand = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Next-state logic; DRAIN leaves on the edge that captures the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_found) state_d = S_ISSUE;
      S_ISSUE: if (last_beat) state_d = rw_q ? S_RESP : S_DRAIN;
      S_DRAIN: if (outstanding_d == '0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM-side drive is only live during ISSUE, otherwise parked at zero.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (state_q == S_ISSUE) begin
      mem_addr_o  = base_q | ADDR_WIDTH'(beat_q);
      mem_wdata_o = wr_word[{grant_q, beat_q}];
      mem_we_o    = rw_q;
    end
  end

  // One-cycle ack to the granted port while in RESP.
  always_comb begin
    resp_ack_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_ack_o[p] = (state_q == S_RESP) && (grant_q == PW'(p));
    end
  end

  // Transfer control: grant latch, beat counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PW'(NUM_PORTS - 1);
      rw_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            rw_q    <= req_rw_i[arb_idx];
            base_q  <= port_addr[arb_idx] & ~OFFSET_MASK;
            beat_q  <= '0;
          end
        end
        S_ISSUE: beat_q   <= beat_q + OW'(1);
        S_RESP:  rr_ptr_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Read-return tracker: beat index travels alongside the RAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q    <= '0;
      outstanding_q <= '0;
      for (int j = 0; j < RD_LATENCY; j++) pipe_idx_q[j] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_push;
      pipe_idx_q[0] <= beat_q;
      for (int j = 1; j < RD_LATENCY; j++) begin
        pipe_vld_q[j] <= pipe_vld_q[j-1];
        pipe_idx_q[j] <= pipe_idx_q[j-1];
      end
      outstanding_q <= outstanding_d;
    end
  end

  // Returning RAM words land in their slot of the read block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        if (rd_capture && (cap_idx == OW'(w))) begin
          rdata_q[w*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed vector table, multi-cycle corner sequences and
// randomized single-port traffic checked against a block-level memory model.
module tb_mem_burst_ctrl;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int NP   = 2;
  localparam int RDL  = 1;
  localparam int RDL3 = 3;
  localparam int NVEC = 7;

  localparam logic [127:0] BLK_A = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] BLK_B = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] BLK_C = 128'h55550000_66661111_77772222_88883333;
  localparam logic [127:0] BLK_D = 128'hD0D0D0D3_C0C0C0C2_B0B0B0B1_A0A0A0A0;

  typedef struct {
    int            port;
    logic          rw;
    logic [15:0]   addr;
    logic [127:0]  wblock;
    int            altCycle;
    logic [15:0]   altAddr;
    int            expAck;
    logic [127:0]  expRdata;
    logic [63:0]   expAddrs;
    logic [15:0]   expWe;
  } TestVector;

  logic clk = 1'b0;
  logic rst;
  logic ramClear;

  logic [NP-1:0]       reqValid, reqRw;
  logic [NP*AW-1:0]    reqAddr;
  logic [NP*BW*DW-1:0] reqWdata;
  logic [NP-1:0]       respAck;
  logic [BW*DW-1:0]    respRdata;
  logic                busy, memWe;
  logic [AW-1:0]       memAddr;
  logic [DW-1:0]       memWdata, memRdata;

  logic [NP-1:0]       reqValid3, reqRw3;
  logic [NP*AW-1:0]    reqAddr3;
  logic [NP*BW*DW-1:0] reqWdata3;
  logic [NP-1:0]       respAck3;
  logic [BW*DW-1:0]    respRdata3;
  logic                busy3, memWe3;
  logic [AW-1:0]       memAddr3;
  logic [DW-1:0]       memWdata3, memRdata3, rd3a, rd3b;

  logic [DW-1:0] ram1 [0:4095];
  logic [DW-1:0] ram3 [0:4095];
  logic [DW-1:0] refMem [0:63];

  int nCompared = 0;
  int nMismatched = 0;

  TestVector vecs [NVEC];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW),
                   .NUM_PORTS(NP), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid), .req_rw_i(reqRw), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .resp_ack_o(respAck), .resp_rdata_o(respRdata),
    .busy_o(busy), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_we_o(memWe), .mem_rdata_i(memRdata));

  mem_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW),
                   .NUM_PORTS(NP), .RD_LATENCY(RDL3)) dutSlow (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid3), .req_rw_i(reqRw3), .req_addr_i(reqAddr3),
    .req_wdata_i(reqWdata3), .resp_ack_o(respAck3), .resp_rdata_o(respRdata3),
    .busy_o(busy3), .mem_addr_o(memAddr3), .mem_wdata_o(memWdata3),
    .mem_we_o(memWe3), .mem_rdata_i(memRdata3));

  // Synchronous RAM behind the fast controller, one cycle read latency.
  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < 4096; i++) ram1[i] <= '0;
    end else if (memWe) begin
      ram1[memAddr[11:0]] <= memWdata;
    end
    memRdata <= ram1[memAddr[11:0]];
  end

  // Synchronous RAM behind the slow controller, three cycle read latency.
  always @(posedge clk) begin
    if (ramClear) begin
      for (int i = 0; i < 4096; i++) ram3[i] <= '0;
    end else if (memWe3) begin
      ram3[memAddr3[11:0]] <= memWdata3;
    end
    rd3a      <= ram3[memAddr3[11:0]];
    rd3b      <= rd3a;
    memRdata3 <= rd3b;
  end

  // Hard stop in case something wedges beyond every local cycle bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one block request on the fast controller, starting just after a
  // rising edge so the next falling edge falls in the IDLE grant cycle (0).
  task automatic applyStimulus(input int port, input logic rw, input logic [15:0] addr,
                               input logic [127:0] wblock, input int altCycle,
                               input logic [15:0] altAddr, output int ackCycle,
                               output logic [127:0] rdataAtAck, output logic [63:0] addrTrace,
                               output logic [15:0] weMask);
    @(posedge clk);
    #1;
    reqValid[port] = 1'b1;
    reqRw[port]    = rw;
    reqAddr[port*AW +: AW]      = addr;
    reqWdata[port*BW*DW +: BW*DW] = wblock;
    ackCycle = -1;
    rdataAtAck = '0;
    addrTrace = '0;
    weMask = '0;
    for (int c = 0; c < 40 && ackCycle < 0; c++) begin
      @(negedge clk);
      if (c == altCycle) reqAddr[port*AW +: AW] = altAddr;
      if (c >= 1 && c <= BW) addrTrace[(c-1)*16 +: 16] = memAddr;
      if (c < 16) weMask[c] = memWe;
      if (respAck[port]) begin
        ackCycle   = c;
        rdataAtAck = respRdata;
        reqValid[port] = 1'b0;
      end
    end
    reqValid[port] = 1'b0;
  endtask

  initial begin
    int            ackCycle, ackSeen, t, p;
    logic [127:0]  rdataAtAck, expRdata, lastRead, blk;
    logic [63:0]   addrTrace, expAddrs, ackTrace, expAckTrace;
    logic [15:0]   weMask, expWe, base, addr;
    logic [31:0]   idleMask, expIdle;
    logic          rw;
    int            port, blkIdx;

    vecs[0] = '{0, 1'b1, 16'h0010, BLK_A, -1, 16'h0000, 5, 128'h0,  64'h0013_0012_0011_0010, 16'h001E};
    vecs[1] = '{0, 1'b0, 16'h0013, '0,    -1, 16'h0000, 6, BLK_A,   64'h0013_0012_0011_0010, 16'h0000};
    vecs[2] = '{1, 1'b1, 16'h0107, BLK_B, -1, 16'h0000, 5, BLK_A,   64'h0107_0106_0105_0104, 16'h001E};
    vecs[3] = '{1, 1'b0, 16'h0104, '0,     2, 16'h0010, 6, BLK_B,   64'h0107_0106_0105_0104, 16'h0000};
    vecs[4] = '{0, 1'b0, 16'h0100, '0,    -1, 16'h0000, 6, 128'h0,  64'h0103_0102_0101_0100, 16'h0000};
    vecs[5] = '{1, 1'b1, 16'hFFFE, BLK_C, -1, 16'h0000, 5, 128'h0,  64'hFFFF_FFFE_FFFD_FFFC, 16'h001E};
    vecs[6] = '{0, 1'b0, 16'hFFFC, '0,    -1, 16'h0000, 6, BLK_C,   64'hFFFF_FFFE_FFFD_FFFC, 16'h0000};

    rst = 1'b1;
    ramClear = 1'b1;
    reqValid = '0; reqRw = '0; reqAddr = '0; reqWdata = '0;
    reqValid3 = '0; reqRw3 = '0; reqAddr3 = '0; reqWdata3 = '0;
    @(posedge clk);
    #1;
    ramClear = 1'b0;
    @(negedge clk);

    checkOutput("reset control outputs",
                {busy, memWe, memAddr, respAck, busy3, memWe3, memAddr3, respAck3}, '0);
    checkOutput("reset rdata", respRdata, '0);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wblock,
                    vecs[i].altCycle, vecs[i].altAddr, ackCycle, rdataAtAck, addrTrace, weMask);
      checkOutput($sformatf("vec%0d ack cycle", i), 128'(ackCycle), 128'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d rdata", i), rdataAtAck, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d addresses", i), 128'(addrTrace), 128'(vecs[i].expAddrs));
      checkOutput($sformatf("vec%0d we cycles", i), 128'(weMask), 128'(vecs[i].expWe));
    end

    $display("[TB] reset during write beat 2");
    @(posedge clk);
    #1;
    reqValid[0] = 1'b1;
    reqRw[0]    = 1'b1;
    reqAddr[0 +: AW] = 16'h0201;
    reqWdata[0 +: BW*DW] = BLK_D;
    repeat (4) @(negedge clk);
    checkOutput("rstmid beat2 drive", {memWe, memAddr, memWdata}, {1'b1, 16'h0202, BLK_D[64 +: 32]});
    rst = 1'b1;
    #1;
    checkOutput("rstmid outputs", {busy, memWe, memAddr, memWdata, respAck}, '0);
    checkOutput("rstmid rdata cleared", respRdata, '0);
    reqValid = '0;
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (respAck != '0) ackSeen++;
    end
    checkOutput("rstmid no ack", 128'(ackSeen), 128'(0));
    checkOutput("rstmid ram words",
                {ram1[12'h203], ram1[12'h202], ram1[12'h201], ram1[12'h200]},
                {32'h0, 32'h0, BLK_D[32 +: 32], BLK_D[0 +: 32]});

    $display("[TB] randomized single-port traffic");
    for (int i = 0; i < 64; i++) refMem[i] = '0;
    lastRead = '0;
    for (int n = 0; n < 24; n++) begin
      port   = int'($urandom_range(0, NP-1));
      rw     = 1'($urandom_range(0, 1));
      blkIdx = int'($urandom_range(0, 15));
      addr   = 16'h0300 + 16'(blkIdx*BW) + 16'($urandom_range(0, BW-1));
      blk    = {$urandom, $urandom, $urandom, $urandom};
      base   = 16'h0300 + 16'(blkIdx*BW);
      expAddrs = '0;
      for (int w = 0; w < BW; w++) expAddrs[w*16 +: 16] = base + 16'(w);
      expWe = '0;
      if (rw) for (int c = 1; c <= BW; c++) expWe[c] = 1'b1;
      if (rw) begin
        for (int w = 0; w < BW; w++) refMem[blkIdx*BW + w] = blk[w*DW +: DW];
        expRdata = lastRead;
      end else begin
        for (int w = 0; w < BW; w++) expRdata[w*DW +: DW] = refMem[blkIdx*BW + w];
        lastRead = expRdata;
      end
      applyStimulus(port, rw, addr, blk, -1, 16'h0, ackCycle, rdataAtAck, addrTrace, weMask);
      checkOutput($sformatf("rand%0d ack cycle", n), 128'(ackCycle),
                  128'(rw ? BW + 1 : BW + RDL + 1));
      checkOutput($sformatf("rand%0d rdata", n), rdataAtAck, expRdata);
      checkOutput($sformatf("rand%0d addresses", n), 128'(addrTrace), 128'(expAddrs));
      checkOutput($sformatf("rand%0d we cycles", n), 128'(weMask), 128'(expWe));
    end
    ackSeen = 0;
    for (int i = 0; i < 64; i++) if (ram1[12'h300 + 12'(i)] !== refMem[i]) ackSeen++;
    checkOutput("rand ram contents", 128'(ackSeen), 128'(0));

    $display("[TB] two ports requesting continuously");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    reqRw = 2'b11;
    reqAddr = {16'h03D0, 16'h03C0};
    reqWdata = {BLK_B, BLK_A};
    reqValid = 2'b11;
    ackTrace = '0;
    idleMask = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      idleMask[c] = !busy;
      ackTrace[2*c +: 2] = respAck;
    end
    reqValid = '0;
    expAckTrace = '0;
    expIdle = '0;
    t = 0;
    p = 0;
    while (t < 30) begin
      expIdle[t] = 1'b1;
      if (t + BW + 1 < 30) expAckTrace[2*(t + BW + 1) + p] = 1'b1;
      t = t + BW + 2;
      p = (p + 1) % NP;
    end
    checkOutput("arb ack sequence", 128'(ackTrace), 128'(expAckTrace));
    checkOutput("arb idle cycles", 128'(idleMask), 128'(expIdle));

    $display("[TB] three-cycle read latency");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    reqValid3[0] = 1'b1;
    reqRw3[0]    = 1'b1;
    reqAddr3[0 +: AW] = 16'h0010;
    reqWdata3[0 +: BW*DW] = BLK_A;
    ackCycle = -1;
    for (int c = 0; c < 40 && ackCycle < 0; c++) begin
      @(negedge clk);
      if (respAck3[0]) begin
        ackCycle = c;
        reqValid3[0] = 1'b0;
      end
    end
    reqValid3[0] = 1'b0;
    checkOutput("slow write ack cycle", 128'(ackCycle), 128'(BW + 1));

    @(posedge clk);
    #1;
    reqValid3[0] = 1'b1;
    reqRw3[0]    = 1'b0;
    reqAddr3[0 +: AW] = 16'h0013;
    ackCycle = -1;
    weMask = '0;
    rdataAtAck = '0;
    for (int c = 0; c < 40 && ackCycle < 0; c++) begin
      @(negedge clk);
      if (c < 16) weMask[c] = memWe3;
      if (respAck3[0]) begin
        ackCycle = c;
        rdataAtAck = respRdata3;
        reqValid3[0] = 1'b0;
      end
    end
    reqValid3[0] = 1'b0;
    checkOutput("slow read ack cycle", 128'(ackCycle), 128'(BW + RDL3 + 1));
    checkOutput("slow read rdata", rdataAtAck, BLK_A);
    checkOutput("slow read no we", 128'(weMask), 128'(0));
    @(negedge clk);
    checkOutput("slow ack single cycle", {126'(0), busy3, respAck3[0]}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Multi-port, parametrised block-transfer memory controller between the cache layer and a single-port synchronous RAM. Arbitrates block read/write requests from NUM_PORTS cache clients (round-robin), moves a whole block as BLOCK_WORDS back-to-back single-word RAM accesses, pipelines reads against a configurable RAM read latency, and returns one ack per request.

## Interface
- ADDR_WIDTH, 16: word address width.
- DATA_WIDTH, 32: RAM word width.
- BLOCK_WORDS, 4: words per block; power of two, ≥2. OW = log2(BLOCK_WORDS).
- NUM_PORTS, 2: number of requesters, 1..8.
- RD_LATENCY, 1: RAM read latency in cycles, 1..4.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_PORTS  per-port request pending; held high until that port's ack.
- req_rw  in  NUM_PORTS  per-port 1 = write block, 0 = read block.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port block address; low OW bits ignored.
- req_wdata  in  NUM_PORTS*BLOCK_WORDS*DATA_WIDTH  per-port write block; word w of port p at slice ((p*BLOCK_WORDS+w)*DATA_WIDTH).
- resp_ack  out  NUM_PORTS  one-cycle pulse to the served port.
- resp_rdata  out  BLOCK_WORDS*DATA_WIDTH  read block, word w at slice w*DATA_WIDTH.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after address.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE: if any req_valid, grant the first requesting port at or after rr_ptr+1 (mod NUM_PORTS); latch grant index, rw and block base {req_addr[ADDR_WIDTH-1:OW], OW'b0}; beat counter = 0; go ISSUE.
- ISSUE: mem_addr = base | beat; mem_we = latched rw; mem_wdata = req_wdata word[beat] of granted port. beat increments each cycle; after beat BLOCK_WORDS-1: write → RESP, read → DRAIN.
- Read capture: each read beat pushes (valid, beat index) into an RD_LATENCY-deep shift register; on emergence, mem_rdata is written into resp_rdata word[index]. Counter of outstanding beats.
- DRAIN: wait until outstanding count = 0 (last capture edge), then RESP.
- RESP: resp_ack[grant] = 1 for exactly one cycle; rr_ptr = grant; go IDLE.
- resp_rdata holds the last completed read block until the next read overwrites it word by word; write transfers never touch it.
- Outside ISSUE: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Port changes req_valid/req_rw/req_addr after grant: ignored (latched). req_wdata must stay stable until ack.
- Requester keeping req_valid high in the cycle after ack is treated as a new request.

## Timing
- Reset (async): state IDLE, rr_ptr = NUM_PORTS-1 (port 0 first), resp_ack = 0, resp_rdata = 0, busy = 0, mem_we = 0, mem_addr = 0, shift register cleared.
- Reset mid-transfer: abort immediately; no ack; RAM words already written stay written.
- Cycle 0 = IDLE cycle with req_valid sampled. ISSUE = cycles 1..BLOCK_WORDS.
- Write: ack in cycle BLOCK_WORDS+1.
- Read: last word captured at end of cycle BLOCK_WORDS+RD_LATENCY; ack in cycle BLOCK_WORDS+RD_LATENCY+1; resp_rdata complete when ack is high.
- Back-to-back: next grant earliest in the cycle after ack (one IDLE cycle between transfers).
- Simultaneous requests: exactly one grant per IDLE cycle; no port is skipped twice in a row while requesting.

## Test plan
- Reset, BLOCK_WORDS=4, RD_LATENCY=1: port 0 writes 0x11,0x22,0x33,0x44 to addr 0x0010 → mem_we high cycles 1-4 at 0x10-0x13, ack[0] at cycle 5.
- Port 0 reads addr 0x0013 (unaligned) → addresses 0x10-0x13 issued, resp_rdata = {0x44,0x33,0x22,0x11} at ack in cycle 6.
- RD_LATENCY=3, same read → ack in cycle 8, identical data; no mem_we pulse.
- Ports 0 and 1 request together continuously → grants alternate 0,1,0,1; each ack one cycle, one IDLE cycle between transfers.
- Assert rst during ISSUE beat 2 of a write → outputs to reset values immediately, no ack, only words 0-1 written.
- Port 1 changes req_addr after grant → transfer uses originally latched address.
